// File: rtl/tlc_pkg.sv
// tlc_pkg: lamp encodings, state codes and phase width shared by the traffic light controller.
package tlc_pkg;
   localparam int PHASE_W = 3;
   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] YEL = 2'b10;
   localparam logic [1:0] GRN = 2'b11;
   localparam logic [1:0] OFF = 2'b01;
   typedef enum logic [PHASE_W-1:0] {
      A_GRN = 3'd0, A_YEL = 3'd1, AR_1 = 3'd2, B_GRN = 3'd3,
      B_YEL = 3'd4, AR_2 = 3'd5, FLASH = 3'd6
   } state_t;
endpackage

// File: rtl/tlc_tick_gen.sv
// tlc_tick_gen: one-cycle tick every CLK_DIV enabled clocks; the count freezes while en is low.
module tlc_tick_gen #(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int CW = $clog2(CLK_DIV);
   logic [CW-1:0] cnt;
   assign tick = en && cnt == CW'(CLK_DIV - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-approach intersection controller with pedestrian green cut and all-red clearance.
// Define TLC_NIGHT_FLASH_EN to add the night port and the flashing-yellow state.
module traffic_light_ctrl
   import tlc_pkg::*;
#(
   parameter int CLK_DIV     = 50_000_000,
   parameter int T_GREEN     = 30,
   parameter int T_MIN_GREEN = 10,
   parameter int T_YELLOW    = 5,
   parameter int T_ALL_RED   = 2,
   parameter int TW          = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               ped_req_a,
   input  logic               ped_req_b,
`ifdef TLC_NIGHT_FLASH_EN
   input  logic               night,
`endif
   output logic [1:0]         light_a,
   output logic [1:0]         light_b,
   output logic               walk_a,
   output logic               walk_b,
   output logic [PHASE_W-1:0] phase
);
   logic tick, nt, pend_a, pend_b, pend_a_n, pend_b_n, walk_a_n, walk_b_n;
   logic [1:0] light_a_n, light_b_n;
   logic [TW-1:0] elapsed, elapsed_n;
   state_t state, state_n;
`ifdef TLC_NIGHT_FLASH_EN
   assign nt = night;
`else
   assign nt = 1'b0;
`endif
   tlc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .en(en), .tick(tick));
   assign phase = state;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= AR_2;
         elapsed <= '0;
         pend_a  <= 1'b0;
         pend_b  <= 1'b0;
         light_a <= RED;
         light_b <= RED;
         walk_a  <= 1'b0;
         walk_b  <= 1'b0;
      end else begin
         state   <= state_n;
         elapsed <= elapsed_n;
         pend_a  <= pend_a_n;
         pend_b  <= pend_b_n;
         light_a <= light_a_n;
         light_b <= light_b_n;
         walk_a  <= walk_a_n;
         walk_b  <= walk_b_n;
      end
   always_comb begin
      state_n = state;
      case (state)
         A_GRN: if (tick && (elapsed == TW'(T_GREEN - 1) || (pend_a && elapsed >= TW'(T_MIN_GREEN - 1)))) state_n = A_YEL;
         A_YEL: if (tick && elapsed == TW'(T_YELLOW - 1)) state_n = AR_1;
         AR_1:  if (tick && elapsed == TW'(T_ALL_RED - 1)) state_n = nt ? FLASH : B_GRN;
         B_GRN: if (tick && (elapsed == TW'(T_GREEN - 1) || (pend_b && elapsed >= TW'(T_MIN_GREEN - 1)))) state_n = B_YEL;
         B_YEL: if (tick && elapsed == TW'(T_YELLOW - 1)) state_n = AR_2;
         AR_2:  if (tick && elapsed == TW'(T_ALL_RED - 1)) state_n = nt ? FLASH : A_GRN;
`ifdef TLC_NIGHT_FLASH_EN
         FLASH: if (tick && !nt) state_n = AR_2;
`endif
         default: state_n = AR_2;
      endcase
      elapsed_n = state_n != state ? '0 : elapsed + TW'(tick);
      // a request is served by the opposite green, so that entry clears it and beats a same-cycle set
      pend_a_n  = (state_n == B_GRN && state != B_GRN) || state_n == FLASH ? 1'b0 : pend_a | ped_req_a;
      pend_b_n  = (state_n == A_GRN && state != A_GRN) || state_n == FLASH ? 1'b0 : pend_b | ped_req_b;
      light_a_n = state_n == A_GRN ? GRN : state_n == A_YEL ? YEL : state_n == FLASH ? (elapsed_n[0] ? OFF : YEL) : RED;
      light_b_n = state_n == B_GRN ? GRN : state_n == B_YEL ? YEL : state_n == FLASH ? (elapsed_n[0] ? OFF : YEL) : RED;
      walk_a_n  = state_n == B_GRN;
      walk_b_n  = state_n == A_GRN;
   end
endmodule
